// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: PHT of 2-bit counters indexed by PC ^ global history,
// speculative history updated in D, trained and repaired from the M stage.
module gshare_predictor #(
    parameter int unsigned PHT_IDX_W = 8,
    parameter int unsigned GHR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pcD,
    input  logic             branchD,
    input  logic             stallD,
    input  logic             flushE,
    input  logic             flushM,
    input  logic             branchM,
    input  logic             actual_takeM,
    output logic             pred_takeD,
    output logic             pred_wrongM,
    output logic [GHR_W-1:0] ghr_spec
);

    localparam int unsigned PhtSize = 2 ** PHT_IDX_W;

    logic [1:0]           pht_q [PhtSize];
    logic [GHR_W-1:0]     ghr_spec_q, ghr_spec_d;
    logic [GHR_W-1:0]     ghr_commit_q;
    logic [PHT_IDX_W-1:0] ghr_ext;
    logic [PHT_IDX_W-1:0] idx_d;
    logic                 leave_d;

    logic                 valid_e_q, pred_e_q;
    logic [PHT_IDX_W-1:0] idx_e_q;
    logic [GHR_W-1:0]     ckpt_e_q;
    logic                 valid_m_q, pred_m_q;
    logic [PHT_IDX_W-1:0] idx_m_q;
    logic [GHR_W-1:0]     ckpt_m_q;

    logic                 res_m;
    logic [1:0]           ctr_upd;

    // Committed history is kept for debug visibility only; upper PC bits never index the table.
    logic                 unused_bits;
    assign unused_bits = ^{pcD[31:PHT_IDX_W+2], pcD[1:0], ghr_commit_q};

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_W-1:0] = ghr_spec_q;
    end

    assign idx_d       = pcD[PHT_IDX_W+1:2] ^ ghr_ext;
    assign pred_takeD  = branchD & pht_q[idx_d][1];
    assign leave_d     = branchD & ~stallD & ~flushE;
    assign res_m       = valid_m_q & branchM;
    assign pred_wrongM = res_m & (pred_m_q ^ actual_takeM);
    assign ghr_spec    = ghr_spec_q;

    // Repair wins over a same-cycle shift: the younger branch in D is being flushed.
    always_comb begin
        ghr_spec_d = ghr_spec_q;
        if (pred_wrongM) begin
            ghr_spec_d = {ckpt_m_q[GHR_W-2:0], actual_takeM};
        end else if (leave_d) begin
            ghr_spec_d = {ghr_spec_q[GHR_W-2:0], pred_takeD};
        end
    end

    always_comb begin
        ctr_upd = pht_q[idx_m_q];
        if (actual_takeM) begin
            if (ctr_upd != 2'b11) ctr_upd = ctr_upd + 2'd1;
        end else if (ctr_upd != 2'b00) begin
            ctr_upd = ctr_upd - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(PhtSize); i++) begin
                pht_q[i] <= 2'b01;
            end
        end else if (res_m) begin
            pht_q[idx_m_q] <= ctr_upd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_spec_q   <= '0;
            ghr_commit_q <= '0;
        end else begin
            ghr_spec_q <= ghr_spec_d;
            if (res_m) begin
                ghr_commit_q <= {ghr_commit_q[GHR_W-2:0], actual_takeM};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_e_q <= 1'b0;
            pred_e_q  <= 1'b0;
            idx_e_q   <= '0;
            ckpt_e_q  <= '0;
            valid_m_q <= 1'b0;
            pred_m_q  <= 1'b0;
            idx_m_q   <= '0;
            ckpt_m_q  <= '0;
        end else begin
            valid_e_q <= leave_d;
            pred_e_q  <= pred_takeD;
            idx_e_q   <= idx_d;
            ckpt_e_q  <= ghr_spec_q;
            valid_m_q <= valid_e_q & ~flushM;
            pred_m_q  <= pred_e_q;
            idx_m_q   <= idx_e_q;
            ckpt_m_q  <= ckpt_e_q;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a table/queue model of the predictor.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcD = '0;
    logic        branchD = 1'b0, stallD = 1'b0, flushE = 1'b0, flushM = 1'b0;
    logic        branchM = 1'b0, actual_takeM = 1'b0;
    logic        pred_takeD, pred_wrongM;
    logic [7:0]  ghr_spec;

    gshare_predictor #(.PHT_IDX_W(8), .GHR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pcD          (pcD),
        .branchD      (branchD),
        .stallD       (stallD),
        .flushE       (flushE),
        .flushM       (flushM),
        .branchM      (branchM),
        .actual_takeM (actual_takeM),
        .pred_takeD   (pred_takeD),
        .pred_wrongM  (pred_wrongM),
        .ghr_spec     (ghr_spec)
    );

    always #5 clk = ~clk;

    // Model: counters as integers, history as a byte, in-flight branches stamped with the
    // cycle they left D; a branch is resolvable in M exactly two cycles later.
    typedef struct {
        int       stamp;
        logic [7:0] idx;
        logic     pred;
        logic [7:0] ckpt;
    } rec_t;

    rec_t        inflight[$];
    int          ctr[256];
    logic [7:0]  ghr_m;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ctr[i] = 1;
        ghr_m = 8'h00;
        inflight.delete();
    endtask

    function automatic int m_slot();
        for (int i = 0; i < inflight.size(); i++) begin
            if (inflight[i].stamp == cyc - 2) return i;
        end
        return -1;
    endfunction

    task automatic compare();
        logic [7:0] idx;
        logic exp_pred, exp_wrong;
        int k;
        idx = pcD[9:2] ^ ghr_m;
        exp_pred = branchD && (ctr[idx] >= 2);
        k = m_slot();
        exp_wrong = (k >= 0) && branchM && (inflight[k].pred != actual_takeM);
        chk("pred_takeD", {31'b0, pred_takeD}, {31'b0, exp_pred});
        chk("pred_wrongM", {31'b0, pred_wrongM}, {31'b0, exp_wrong});
        chk("ghr_spec", {24'b0, ghr_spec}, {24'b0, ghr_m});
    endtask

    task automatic model_step();
        logic [7:0] idx, old_ghr;
        logic pred, leave, wrong;
        int k;
        rec_t r;
        idx = pcD[9:2] ^ ghr_m;
        pred = branchD && (ctr[idx] >= 2);
        leave = branchD && !stallD && !flushE;
        old_ghr = ghr_m;
        k = m_slot();
        wrong = 1'b0;
        if (k >= 0 && branchM) begin
            r = inflight[k];
            wrong = (r.pred != actual_takeM);
            if (actual_takeM) ctr[r.idx] = (ctr[r.idx] == 3) ? 3 : ctr[r.idx] + 1;
            else              ctr[r.idx] = (ctr[r.idx] == 0) ? 0 : ctr[r.idx] - 1;
            if (wrong) ghr_m = {r.ckpt[6:0], actual_takeM};
        end
        if (!wrong && leave) ghr_m = {ghr_m[6:0], pred};
        for (int i = inflight.size() - 1; i >= 0; i--) begin
            if (inflight[i].stamp <= cyc - 2 || (flushM && inflight[i].stamp == cyc - 1))
                inflight.delete(i);
        end
        if (leave) begin
            r.stamp = cyc;
            r.idx = idx;
            r.pred = pred;
            r.ckpt = old_ghr;
            inflight.push_back(r);
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic idle();
        branchD = 0; stallD = 0; flushE = 0; flushM = 0; branchM = 0; actual_takeM = 0;
        pcD = '0;
    endtask

    task automatic br(input logic [31:0] pc, input logic taken);
        branchD = 1; pcD = pc;
        tick();
        branchD = 0;
        tick();
        branchM = 1; actual_takeM = taken;
        tick();
        branchM = 0; actual_takeM = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        #1;
        chk("reset_ghr", {24'b0, ghr_spec}, 32'h0);
        chk("reset_wrong", {31'b0, pred_wrongM}, 32'h0);
        tick();
        rst = 1;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();
        idle();

        // Fresh predictor: weakly not-taken everywhere.
        branchD = 1; pcD = 32'h40;
        #1;
        chk("t1_pred", {31'b0, pred_takeD}, 32'h0);
        chk("t1_ghr", {24'b0, ghr_spec}, 32'h0);
        branchD = 0;
        tick();

        // Always-taken loop branch fills history with ones and trains entry 0xEF.
        for (int i = 0; i < 12; i++) br(32'h40, 1'b1);
        branchD = 1; pcD = 32'h40;
        #1;
        chk("t2_ghr", {24'b0, ghr_spec}, 32'hFF);
        chk("t2_pred", {31'b0, pred_takeD}, 32'h1);
        branchD = 0;

        // Saturated entry 0xEF: one not-taken only drops it to weakly taken.
        br(32'h40, 1'b0);
        chk("t4_ghr_repair", {24'b0, ghr_spec}, 32'hFE);
        branchD = 1; pcD = 32'h44;
        #1;
        chk("t4_sat_pred", {31'b0, pred_takeD}, 32'h1);
        idle();
        tick();

        // Mid-stream reset with a branch in flight.
        branchD = 1; pcD = 32'h40;
        tick();
        branchD = 1;
        do_reset();
        #1;
        chk("rst_pred", {31'b0, pred_takeD}, 32'h0);
        idle();
        branchM = 1; actual_takeM = 1;
        tick();
        idle();

        // Build ghr_spec = 0x05, then two in-flight branches and a repair.
        br(32'h40, 1'b1);
        br(32'h40, 1'b0);
        br(32'h40, 1'b1);
        chk("t3_ghr_start", {24'b0, ghr_spec}, 32'h05);
        branchD = 1; pcD = 32'h40;
        #1;
        chk("t3_predA", {31'b0, pred_takeD}, 32'h0);
        tick();
        chk("t3_ghrA", {24'b0, ghr_spec}, 32'h0A);
        tick();
        chk("t3_ghrB", {24'b0, ghr_spec}, 32'h14);
        branchD = 0; branchM = 1; actual_takeM = 1; flushM = 1;
        #1;
        chk("t3_wrong", {31'b0, pred_wrongM}, 32'h1);
        tick();
        chk("t3_ghr_fix", {24'b0, ghr_spec}, 32'h0B);
        idle();
        tick();

        // Stalled branch shifts history exactly once.
        branchD = 1; pcD = 32'h40; stallD = 1;
        repeat (3) tick();
        stallD = 0;
        tick();
        branchD = 0;
        chk("t5_ghr", {24'b0, ghr_spec}, 32'h16);

        // Branch killed by flushM while in E: no mispredict, no training.
        flushM = 1;
        tick();
        flushM = 0; branchM = 1; actual_takeM = 1;
        #1;
        chk("t6_wrong", {31'b0, pred_wrongM}, 32'h0);
        tick();
        idle();
        chk("t6_ghr", {24'b0, ghr_spec}, 32'h16);
        branchD = 1; pcD = 32'h34;
        #1;
        chk("t6_pht", {31'b0, pred_takeD}, 32'h0);
        idle();
        tick();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) pcD = $urandom;
            else pcD = 32'h40 + {$urandom_range(0, 7), 2'b00};
            branchD = ($urandom_range(0, 9) < 7);
            stallD = ($urandom_range(0, 9) < 2);
            flushE = ($urandom_range(0, 9) == 0);
            flushM = ($urandom_range(0, 9) == 0);
            branchM = ($urandom_range(0, 9) < 8);
            actual_takeM = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 0;
                model_reset();
            end else begin
                rst = 1;
            end
            tick();
        end
        rst = 1;
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
